// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting logic:
// FSM state encoding, field indices, per-field limits and wrap helpers.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Field index as shown on the cursor output
  localparam logic [2:0] FLD_YEAR  = 3'd0;
  localparam logic [2:0] FLD_MONTH = 3'd1;
  localparam logic [2:0] FLD_DAY   = 3'd2;
  localparam logic [2:0] FLD_HOUR  = 3'd3;
  localparam logic [2:0] FLD_MIN   = 3'd4;
  localparam logic [2:0] FLD_SEC   = 3'd5;

  // Per-field limits (year upper bound is a module parameter)
  localparam logic [7:0] YEAR_MIN  = 8'd0;
  localparam logic [7:0] MONTH_MIN = 8'd1;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] DAY_MIN   = 8'd1;
  localparam logic [7:0] DAY_MAX   = 8'd31;
  localparam logic [7:0] HOUR_MIN  = 8'd0;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MIN   = 8'd0;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] SEC_MIN   = 8'd0;
  localparam logic [7:0] SEC_MAX   = 8'd59;

  // Button bit positions in sw_in
  localparam int SW_DOWN    = 0;
  localparam int SW_UP      = 1;
  localparam int SW_NEXT    = 2;
  localparam int SW_CONFIRM = 3;

  // One step up or down inside [lo, hi], wrapping at both ends
  function automatic logic [7:0] step_wrap(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi, input logic up);
    if (up) return (v >= hi) ? lo : v + 8'd1;
    else    return (v <= lo) ? hi : v - 8'd1;
  endfunction

  // Calendar length of a month; leap years are those divisible by four
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'd2:                     return (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:  return 8'd30;
      default:                  return DAY_MAX;
    endcase
  endfunction

endpackage

// File: rtl/sw_edge.sv
// Registered rising-edge detector for a bank of button levels.
// The pulse is high in the cycle the level is first seen high.
module sw_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  // Remember last cycle's button levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= sw;
  end

  assign rise = sw & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures the running time, lets the user edit
// each field with next/up/down buttons, and emits a one-cycle load strobe
// with the edited time on confirm.
// Optional macro MONTH_DAYS_EN: day limit follows the month (with leap
// years) and the day is clamped when month or year changes; otherwise the
// day always ranges 1..31.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int YEAR_MAX = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic [3:0]  sw_in,
  input  logic [7:0]  year,
  input  logic [7:0]  month,
  input  logic [7:0]  day,
  input  logic [7:0]  hour,
  input  logic [7:0]  minute,
  input  logic [7:0]  second,
  output logic [47:0] bin_time,
  output logic        en_time,
  output logic [2:0]  cursor,
  output logic        busy
);

  localparam logic [7:0] YMAX = 8'(YEAR_MAX);

  state_t     state_q, state_n;
  logic       active_q;
  logic       armed_q;
  logic       act_rise;
  logic [3:0] sw_rise;

  logic [7:0] year_sh, month_sh, day_sh, hour_sh, min_sh, sec_sh;
  logic [7:0] year_n, month_n, day_n, hour_n, min_n, sec_n;
  logic [2:0] cursor_n;
  logic [7:0] ld_dmax;
  logic [7:0] cur_dmax;
`ifdef MONTH_DAYS_EN
  logic [7:0] new_dmax;
`endif
  logic       do_confirm;

  sw_edge #(.W(4)) u_sw_edge (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw_in),
    .rise (sw_rise)
  );

  // armed_q blocks a false "rise" when active is already high at reset release
  assign act_rise   = active & ~active_q & armed_q;
  assign do_confirm = (state_q == ST_EDIT) && active && sw_rise[SW_CONFIRM];

  // State register and set-mode request edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      active_q <= active;
      armed_q  <= 1'b1;
    end
  end

  // Next-state: dropping active cancels and takes priority over confirm
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:   if (act_rise) state_n = ST_LOAD;
      ST_LOAD:   state_n = active ? ST_EDIT : ST_IDLE;
      ST_EDIT: begin
        if (!active)                      state_n = ST_IDLE;
        else if (sw_rise[SW_CONFIRM])     state_n = ST_COMMIT;
      end
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Shadow field updates: capture with range repair, then button edits
  always_comb begin
    year_n   = year_sh;
    month_n  = month_sh;
    day_n    = day_sh;
    hour_n   = hour_sh;
    min_n    = min_sh;
    sec_n    = sec_sh;
    cursor_n = cursor;
    ld_dmax  = DAY_MAX;
    cur_dmax = DAY_MAX;
`ifdef MONTH_DAYS_EN
    new_dmax = DAY_MAX;
    cur_dmax = days_in_month(month_sh, year_sh);
`endif
    case (state_q)
      ST_LOAD: begin
        year_n  = (year > YMAX) ? YEAR_MIN : year;
        month_n = (month < MONTH_MIN || month > MONTH_MAX) ? MONTH_MIN : month;
`ifdef MONTH_DAYS_EN
        ld_dmax = days_in_month(month_n, year_n);
`endif
        day_n    = (day < DAY_MIN || day > ld_dmax) ? DAY_MIN : day;
        hour_n   = (hour   > HOUR_MAX) ? HOUR_MIN : hour;
        min_n    = (minute > MIN_MAX)  ? MIN_MIN  : minute;
        sec_n    = (second > SEC_MAX)  ? SEC_MIN  : second;
        cursor_n = FLD_YEAR;
      end
      ST_EDIT: begin
        if (active && !sw_rise[SW_CONFIRM]) begin
          if (sw_rise[SW_NEXT]) begin
            cursor_n = (cursor == FLD_SEC) ? FLD_YEAR : cursor + 3'd1;
          end else if (sw_rise[SW_UP] ^ sw_rise[SW_DOWN]) begin
            case (cursor)
              FLD_YEAR:  year_n  = step_wrap(year_sh,  YEAR_MIN,  YMAX,      sw_rise[SW_UP]);
              FLD_MONTH: month_n = step_wrap(month_sh, MONTH_MIN, MONTH_MAX, sw_rise[SW_UP]);
              FLD_DAY:   day_n   = step_wrap(day_sh,   DAY_MIN,   cur_dmax,  sw_rise[SW_UP]);
              FLD_HOUR:  hour_n  = step_wrap(hour_sh,  HOUR_MIN,  HOUR_MAX,  sw_rise[SW_UP]);
              FLD_MIN:   min_n   = step_wrap(min_sh,   MIN_MIN,   MIN_MAX,   sw_rise[SW_UP]);
              FLD_SEC:   sec_n   = step_wrap(sec_sh,   SEC_MIN,   SEC_MAX,   sw_rise[SW_UP]);
              default:   ;
            endcase
`ifdef MONTH_DAYS_EN
            // A day edit stays within the current month, so clamping here
            // only ever bites when month or year just changed
            new_dmax = days_in_month(month_n, year_n);
            if (day_n > new_dmax) day_n = new_dmax;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  // Shadow registers and cursor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year_sh  <= '0;
      month_sh <= '0;
      day_sh   <= '0;
      hour_sh  <= '0;
      min_sh   <= '0;
      sec_sh   <= '0;
      cursor   <= FLD_YEAR;
    end else begin
      year_sh  <= year_n;
      month_sh <= month_n;
      day_sh   <= day_n;
      hour_sh  <= hour_n;
      min_sh   <= min_n;
      sec_sh   <= sec_n;
      cursor   <= cursor_n;
    end
  end

  // Committed time: loaded on the confirm edge so it is valid during COMMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            bin_time <= '0;
    else if (do_confirm) bin_time <= {year_sh, month_sh, day_sh, hour_sh, min_sh, sec_sh};
  end

  assign en_time = (state_q == ST_COMMIT);
  assign busy    = (state_q == ST_LOAD) || (state_q == ST_EDIT);

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: YEAR_MAX, 99, upper bound of year field (binary, lower bound 0).
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: active  input  1  set-mode request level; rising edge enters set mode, low cancels.
REQ-005 Port: sw_in  input  4  raw button levels: [0]=down, [1]=up, [2]=next field, [3]=confirm.
REQ-006 Port: year, month, day, hour, minute, second  input  8 each  current running time, binary.
REQ-007 Port: bin_time  output  48  edited time {year,month,day,hour,minute,second}, [7:0]=second, [47:40]=year.
REQ-008 Port: en_time  output  1  one-cycle load strobe qualifying bin_time.
REQ-009 Port: cursor  output  3  field under edit: 0=year, 1=month, 2=day, 3=hour, 4=minute, 5=second.
REQ-010 Port: busy  output  1  high while in LOAD or EDIT.

Function
REQ-011 States SHALL be IDLE, LOAD, EDIT, COMMIT; IDLE->LOAD on active rising edge (registered previous value).
REQ-012 LOAD SHALL capture all six inputs into shadow registers in one cycle, set cursor=0, then go to EDIT.
REQ-013 LOAD SHALL replace any out-of-range captured field with that field's minimum.
REQ-014 In EDIT, sw_in SHALL be acted on only on rising edges, one action per press, detected by registered previous level.
REQ-015 Edge priority in one cycle: confirm > next > up/down; up and down together SHALL be ignored.
REQ-016 next SHALL advance cursor 0->1->...->5->0.
REQ-017 up/down SHALL change the cursor field by +/-1 with wrap: year 0..YEAR_MAX, month 1..12, day 1..day_max, hour 0..23, minute 0..59, second 0..59.
REQ-018 confirm SHALL go to COMMIT; COMMIT drives en_time=1 for exactly one cycle with bin_time equal to shadow values, then IDLE.
REQ-019 bin_time SHALL hold its last committed value outside COMMIT; en_time=0 in all states but COMMIT.
REQ-020 active low while in LOAD or EDIT SHALL return to IDLE next cycle with no en_time and bin_time unchanged.
REQ-021 active low coincident with confirm edge SHALL cancel (cancel wins).
REQ-022 Latency: confirm edge sampled at edge N -> en_time high during cycle N+1.

Reset
REQ-023 rst low SHALL asynchronously force state=IDLE, bin_time=0, en_time=0, cursor=0, busy=0, shadows=0, edge-detect registers=0.
REQ-024 A button held across reset release SHALL count as at most one press.

Configuration
REQ-025 Macro MONTH_DAYS_EN: defined -> day_max follows month (30 for 4/6/9/11, 28 for 2, 29 for 2 when year%4==0, else 31) and day SHALL be clamped to day_max on the same edge that changes month or year; undefined -> day_max=31, no clamping.

Structure
REQ-026 Package watch_pkg SHALL hold the state enum, field-index constants (FLD_YEAR..FLD_SEC) and per-field min/max constants.
REQ-027 Sub-module sw_edge (4-bit registered rising-edge detector, clk/rst) SHALL be instantiated once for sw_in.

Verification
REQ-028 Inputs 24/3/15 10:20:30, active rise, next x3, up x2, confirm -> one en_time pulse, bin_time=0x18030F0C141E.
REQ-029 EDIT cursor=5, second=59, up -> second=0; cursor=0, year=0, down -> year=99; next from cursor 5 -> 0.
REQ-030 EDIT, active dropped in same cycle as confirm edge -> no en_time, bin_time unchanged, state IDLE, busy=0.
REQ-031 MONTH_DAYS_EN, 23/1/31, set month=2 -> day=28; year 24 -> day max 29; macro undefined -> day stays 31.
REQ-032 sw_in[1] held 100 cycles -> single increment; up+down same cycle -> no change.
REQ-033 rst asserted mid-EDIT -> all outputs 0 immediately; hold active high through release -> stays IDLE until new active rise.
